interval_timer_ctrl: RTL and testbench

//  Controller that sequences an enable-gated up-counter as a programmable interval timer.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/timer_tick_gen.sv | 60 ++++++
 rtl/interval_timer_ctrl.sv | 140 ++++++++++++++
 tb/tb_interval_timer_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the interval timer controller and its
// prescaler. Provides the two-state FSM enum, the one-shot / periodic mode
// encodings and the default datapath widths.
// ---------------------------------------------------------------------------
package timer_pkg;

   // Default count width (Q, LIMIT) and prescaler width (PRESC)
   localparam int DEF_WIDTH   = 16;
   localparam int DEF_PRESC_W = 8;

   // Controller states: idle (holding count) or running (counting ticks)
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Mode encodings as sampled from the MODE input on an accepted start
   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_tick_gen.sv
// ---------------------------------------------------------------------------
// timer_tick_gen
// Prescaler for the interval timer. While enabled it counts clocks and
// raises tick_o for one cycle every (presc_i + 1) clocks. The tick is a
// decode of the current prescaler value, so it appears in the same cycle
// the prescaler reaches the latched PRESC value.
//
// Ports
//   clk_i     clock, all logic on the rising edge
//   rst_i     synchronous active-high reset
//   clear_i   forces the prescaler back to zero (used on an accepted start)
//   enable_i  advances the prescaler; high while the controller is running
//   presc_i   latched prescale value, tick every presc_i+1 clocks
//   tick_o    one-cycle tick
// ---------------------------------------------------------------------------
module timer_tick_gen
   import timer_pkg::*;
#(
   parameter int PRESC_W = DEF_PRESC_W
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clear_i,
   input  logic               enable_i,
   input  logic [PRESC_W-1:0] presc_i,
   output logic               tick_o
);

   logic [PRESC_W-1:0] cnt_q;
   logic [PRESC_W-1:0] cnt_d;

   // The tick fires in the cycle the prescaler matches the terminal value,
   // so PRESC=0 yields a tick on every enabled clock.
   assign tick_o = enable_i && (cnt_q == presc_i);

   // Next prescaler value: clear wins so that a restart discards any pending
   // tick phase; otherwise wrap to zero on a tick and increment in between.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         if (cnt_q == presc_i) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + PRESC_W'(1);
         end
      end
   end

   // Prescaler register with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/interval_timer_ctrl.sv
// ---------------------------------------------------------------------------
// interval_timer_ctrl
// Programmable interval timer controller. Owns the IDLE/RUN FSM, the
// prescaler (via timer_tick_gen), the count register and the terminal-count
// compare. Counts 0..LIMIT inclusive, one step per prescaler tick, and on
// the terminal tick pulses done_o for one cycle and sets the sticky irq_o.
// One-shot mode returns to idle holding LIMIT; periodic mode wraps to zero.
//
// Ports
//   clk_i      clock, all logic on the rising edge
//   rst_i      synchronous active-high reset
//   start_i    one-cycle request: latch limit/presc/mode, clear count, run
//   stop_i     one-cycle request: halt holding the count (beats start/tick)
//   clr_irq_i  clears irq_o (a simultaneous terminal tick wins)
//   mode_i     0 one-shot, 1 periodic, sampled on an accepted start
//   limit_i    terminal count, sampled on an accepted start
//   presc_i    tick every presc_i+1 clocks, sampled on an accepted start
//   q_o        current count
//   busy_o     high while running
//   done_o     one-cycle pulse after the terminal tick
//   irq_o      sticky terminal flag
// ---------------------------------------------------------------------------
module interval_timer_ctrl
   import timer_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int PRESC_W = DEF_PRESC_W
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic               clr_irq_i,
   input  logic               mode_i,
   input  logic [WIDTH-1:0]   limit_i,
   input  logic [PRESC_W-1:0] presc_i,
   output logic [WIDTH-1:0]   q_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               irq_o
);

   state_e             state_q;
   logic [WIDTH-1:0]   count_q;
   logic [WIDTH-1:0]   limitLat_q;
   logic [PRESC_W-1:0] prescLat_q;
   logic               modeLat_q;
   logic               busy_q;
   logic               done_q;
   logic               irq_q;

   logic               running;
   logic               startAcc;
   logic               tick;
   logic               atLimit;
   logic               terminal;

   // Decode of the request priorities. A start is only accepted when stop is
   // not asserted in the same cycle. A tick is only acted upon when neither
   // stop nor start is present, because both of those discard it.
   assign running  = (state_q == ST_RUN);
   assign startAcc = start_i && !stop_i;
   assign atLimit  = (count_q == limitLat_q);
   assign terminal = tick && atLimit && !stop_i && !start_i;

   // The prescaler restarts from zero on every accepted start and only
   // advances while running, so the first tick after a start lands exactly
   // PRESC+1 clocks later.
   timer_tick_gen #(
      .PRESC_W (PRESC_W)
   ) u_tick_gen (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (startAcc),
      .enable_i (running),
      .presc_i  (prescLat_q),
      .tick_o   (tick)
   );

   // Controller FSM together with the count, latched configuration and the
   // registered BUSY/DONE/IRQ outputs. DONE defaults low each cycle so it can
   // only ever be a single-cycle pulse. IRQ is updated outside the state
   // decode so that a terminal tick always beats a same-cycle clear.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         limitLat_q <= '0;
         prescLat_q <= '0;
         modeLat_q  <= MODE_ONESHOT;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         done_q <= terminal;

         if (terminal) begin
            irq_q <= 1'b1;
         end else if (clr_irq_i) begin
            irq_q <= 1'b0;
         end

         if (state_q == ST_IDLE) begin
            if (startAcc) begin
               limitLat_q <= limit_i;
               prescLat_q <= presc_i;
               modeLat_q  <= mode_i;
               count_q    <= '0;
               state_q    <= ST_RUN;
               busy_q     <= 1'b1;
            end
         end else begin
            if (stop_i) begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end else if (start_i) begin
               limitLat_q <= limit_i;
               prescLat_q <= presc_i;
               modeLat_q  <= mode_i;
               count_q    <= '0;
            end else if (tick) begin
               if (!atLimit) begin
                  count_q <= count_q + WIDTH'(1);
               end else if (modeLat_q == MODE_ONESHOT) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  count_q <= '0;
               end
            end
         end
      end
   end

   assign q_o    = count_q;
   assign busy_o = busy_q;
   assign done_o = done_q;
   assign irq_o  = irq_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_interval_timer_ctrl
// Directed bench for the interval timer controller. Each step drives the
// inputs for one clock, queues the outputs expected after that edge and
// compares them one time unit after the edge.
// ---------------------------------------------------------------------------
module tb_interval_timer_ctrl;

   logic        clock;
   logic        reset;
   logic        start;
   logic        stop;
   logic        clrIrq;
   logic        mode;
   logic [15:0] limit;
   logic [7:0]  presc;
   logic [15:0] q;
   logic        busy;
   logic        done;
   logic        irq;

   typedef struct {
      logic [15:0] q;
      logic        busy;
      logic        done;
      logic        irq;
      string       tag;
   } exp_t;

   exp_t sbQ[$];
   int   checks = 0;
   int   errors = 0;
   int   doneSeen;

   interval_timer_ctrl #(
      .WIDTH   (16),
      .PRESC_W (8)
   ) dut (
      .clk_i     (clock),
      .rst_i     (reset),
      .start_i   (start),
      .stop_i    (stop),
      .clr_irq_i (clrIrq),
      .mode_i    (mode),
      .limit_i   (limit),
      .presc_i   (presc),
      .q_o       (q),
      .busy_o    (busy),
      .done_o    (done),
      .irq_o     (irq)
   );

   // Free-running 10 time-unit clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Safety net so the run always ends even if the stimulus stalls
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Pop the expectation for this edge and compare every output against it
   task automatic checkOutput();
      exp_t e;
      checks++;
      assert (sbQ.size() != 0) else begin
         errors++;
         $error("[TB] FAIL scoreboard observed empty expected entry");
      end
      if (sbQ.size() == 0) return;
      e = sbQ.pop_front();
      checks++;
      assert (q === e.q) else begin
         errors++;
         $error("[TB] FAIL %s.q observed %0d expected %0d", e.tag, q, e.q);
      end
      checks++;
      assert (busy === e.busy) else begin
         errors++;
         $error("[TB] FAIL %s.busy observed %b expected %b", e.tag, busy, e.busy);
      end
      checks++;
      assert (done === e.done) else begin
         errors++;
         $error("[TB] FAIL %s.done observed %b expected %b", e.tag, done, e.done);
      end
      checks++;
      assert (irq === e.irq) else begin
         errors++;
         $error("[TB] FAIL %s.irq observed %b expected %b", e.tag, irq, e.irq);
      end
   endtask

   // Drive one cycle of control inputs, queue the expected post-edge outputs,
   // clock once and check
   task automatic applyStimulus(input logic r, input logic st, input logic sp,
                                input logic cl, input string tag,
                                input logic [15:0] eq, input logic eb,
                                input logic ed, input logic ei);
      exp_t e;
      reset  = r;
      start  = st;
      stop   = sp;
      clrIrq = cl;
      e.q    = eq;
      e.busy = eb;
      e.done = ed;
      e.irq  = ei;
      e.tag  = tag;
      sbQ.push_back(e);
      @(posedge clock);
      #1;
      checkOutput();
   endtask

   // Directed sequence
   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      stop   = 1'b0;
      clrIrq = 1'b0;
      mode   = 1'b0;
      limit  = 16'd0;
      presc  = 8'd0;

      // Reset state
      applyStimulus(1, 0, 0, 0, "reset0", 16'd0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, "reset1", 16'd0, 0, 0, 0);

      // One-shot, LIMIT=5, PRESC=0
      limit = 16'd5; presc = 8'd0; mode = 1'b0;
      applyStimulus(0, 1, 0, 0, "osStart", 16'd0, 1, 0, 0);
      for (int n = 1; n <= 5; n++)
         applyStimulus(0, 0, 0, 0, "osCount", 16'(n), 1, 0, 0);
      applyStimulus(0, 0, 0, 0, "osTerm", 16'd5, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, "osHold0", 16'd5, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, "osHold1", 16'd5, 0, 0, 1);
      applyStimulus(0, 0, 0, 1, "osClrIrq", 16'd5, 0, 0, 0);

      // Periodic, LIMIT=3, PRESC=2: Q steps every 3 clocks, DONE every 12
      limit = 16'd3; presc = 8'd2; mode = 1'b1;
      applyStimulus(0, 1, 0, 0, "perStart", 16'd0, 1, 0, 0);
      doneSeen = 0;
      for (int t = 1; t <= 36; t++) begin
         applyStimulus(0, 0, 0, 0, "perRun", 16'((t / 3) % 4), 1,
                       (t % 12) == 0, t >= 12);
         if (done === 1'b1) doneSeen++;
      end
      checks++;
      assert (doneSeen == 3) else begin
         errors++;
         $error("[TB] FAIL perDoneCount observed %0d expected 3", doneSeen);
      end
      applyStimulus(0, 0, 1, 0, "perStop", 16'd0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1, "perClr", 16'd0, 0, 0, 0);

      // STOP on the terminal-tick cycle, then START+STOP combinations
      limit = 16'd2; presc = 8'd0; mode = 1'b0;
      applyStimulus(0, 1, 0, 0, "svStart", 16'd0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, "svCount1", 16'd1, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, "svCount2", 16'd2, 1, 0, 0);
      applyStimulus(0, 0, 1, 0, "stopVsTerm", 16'd2, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, "stopHold", 16'd2, 0, 0, 0);
      applyStimulus(0, 1, 1, 0, "startStopIdle", 16'd2, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, "svStart2", 16'd0, 1, 0, 0);
      applyStimulus(0, 1, 1, 0, "startStopRun", 16'd0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, "svIdle", 16'd0, 0, 0, 0);

      // Restart at Q=2 with new LIMIT/PRESC; later input changes ignored
      limit = 16'd5; presc = 8'd0; mode = 1'b0;
      applyStimulus(0, 1, 0, 0, "rsStart", 16'd0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, "rsCount1", 16'd1, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, "rsCount2", 16'd2, 1, 0, 0);
      limit = 16'd1; presc = 8'd1;
      applyStimulus(0, 1, 0, 0, "restart", 16'd0, 1, 0, 0);
      limit = 16'd7; presc = 8'd0; mode = 1'b1;
      applyStimulus(0, 0, 0, 0, "rsPre", 16'd0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, "rsStep", 16'd1, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, "rsPre2", 16'd1, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, "rsTerm", 16'd1, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, "rsIdle", 16'd1, 0, 0, 1);

      // IRQ race and LIMIT=0 periodic (DONE every clock)
      applyStimulus(0, 0, 0, 1, "irqClr", 16'd1, 0, 0, 0);
      limit = 16'd0; presc = 8'd0; mode = 1'b1;
      applyStimulus(0, 1, 0, 0, "l0Start", 16'd0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, "l0Term", 16'd0, 1, 1, 1);
      applyStimulus(0, 0, 0, 1, "irqRace", 16'd0, 1, 1, 1);
      for (int n = 0; n < 3; n++)
         applyStimulus(0, 0, 0, 0, "l0Every", 16'd0, 1, 1, 1);
      applyStimulus(0, 0, 1, 1, "l0StopClr", 16'd0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, "l0Idle", 16'd0, 0, 0, 0);

      // Reset in the middle of a periodic run with IRQ set
      limit = 16'd1; presc = 8'd0; mode = 1'b1;
      applyStimulus(0, 1, 0, 0, "mrStart", 16'd0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, "mrCount", 16'd1, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, "mrTerm", 16'd0, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, "mrCount2", 16'd1, 1, 0, 1);
      applyStimulus(1, 1, 0, 0, "midReset0", 16'd0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, "midReset1", 16'd0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, "postReset", 16'd0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
